// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry retirement FIFO between the ALU/rotater and writeback.
// The architectural N/Z/V/C flags are committed only when an entry retires.
module alu_result_stage #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic [3:0]   in_flags_n_z_v_c,
  input  logic         in_set_flags,
  input  logic [2:0]   in_rd,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [2:0]   out_rd,
  output logic [3:0]   flags_n_z_v_c,
  output logic [1:0]   count
);

  typedef struct packed {
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic         set_flags;
    logic [2:0]   rd;
  } entry_t;

  entry_t       mem [2];
  entry_t       in_entry;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;
  logic [3:0]   flags_q;
  logic [N-1:0] head_result_q;
  logic [2:0]   head_rd_q;

  logic         push;
  logic         pop;
  logic         load_head;
  logic [N-1:0] head_result_d;
  logic [2:0]   head_rd_d;

  assign in_entry = '{result: in_result, flags: in_flags_n_z_v_c,
                      set_flags: in_set_flags, rd: in_rd};

  // Handshakes look only at registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // NOTE: storage carries no reset; occupancy (count_q) alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers, occupancy and architectural flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      flags_q <= 4'b0000;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (mem[rd_ptr].set_flags) begin
          flags_q <= mem[rd_ptr].flags;
        end
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The head is kept in its own registers so the outputs hold their last value
  // when the FIFO empties instead of following a stale storage slot.
  always_comb begin
    load_head     = 1'b0;
    head_result_d = in_entry.result;
    head_rd_d     = in_entry.rd;
    if (!flush) begin
      if (pop) begin
        if (count_q == 2'd2) begin
          load_head     = 1'b1;
          head_result_d = mem[~rd_ptr].result;
          head_rd_d     = mem[~rd_ptr].rd;
        end else if (push) begin
          load_head = 1'b1;
        end
      end else if (push && (count_q == 2'd0)) begin
        load_head = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_result_q <= '0;
      head_rd_q     <= 3'd0;
    end else if (load_head) begin
      head_result_q <= head_result_d;
      head_rd_q     <= head_rd_d;
    end
  end

  assign out_result    = head_result_q;
  assign out_rd        = head_rd_q;
  assign flags_n_z_v_c = flags_q;
  assign count         = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed steps with a scoreboard
// queue of expected entries and a reference flags register.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [3:0] in_flags_n_z_v_c;
  logic       in_set_flags;
  logic [2:0] in_rd;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_rd;
  logic [3:0] flags_n_z_v_c;
  logic [1:0] count;

  typedef struct {
    logic [7:0] result;
    logic [3:0] flags;
    logic       sf;
    logic [2:0] rd;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_flags;
  logic [7:0] disp_result;
  logic [2:0] disp_rd;
  int         checks   = 0;
  int         failures = 0;

  alu_result_stage #(.N(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_result        (in_result),
    .in_flags_n_z_v_c (in_flags_n_z_v_c),
    .in_set_flags     (in_set_flags),
    .in_rd            (in_rd),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .flags_n_z_v_c    (flags_n_z_v_c),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},     32'(count),         32'd0);
    check({tag, "_in_ready"},  32'(in_ready),      32'd1);
    check({tag, "_out_valid"}, 32'(out_valid),     32'd0);
    check({tag, "_flags"},     32'(flags_n_z_v_c), 32'd0);
    check({tag, "_result"},    32'(out_result),    32'd0);
    check({tag, "_rd"},        32'(out_rd),        32'd0);
  endtask

  // One clock cycle: drive inputs, check handshakes and the retiring entry before
  // the edge, update the scoreboard, then check state #1 after the edge.
  task automatic cycle(input logic v, input logic [7:0] res, input logic [3:0] fl,
                       input logic sf, input logic [2:0] rd, input logic ordy,
                       input logic fsh, input string tag);
    bit   do_push;
    bit   do_pop;
    exp_t e;
    in_valid         = v;
    in_result        = res;
    in_flags_n_z_v_c = fl;
    in_set_flags     = sf;
    in_rd            = rd;
    out_ready        = ordy;
    flush            = fsh;
    check({tag, "_in_ready"},  32'(in_ready),  32'(q.size() != 2));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    do_pop  = ordy && (q.size() != 0) && !fsh;
    do_push = v && (q.size() != 2) && !fsh;
    if (do_pop) begin
      check({tag, "_pop_result"}, 32'(out_result), 32'(q[0].result));
      check({tag, "_pop_rd"},     32'(out_rd),     32'(q[0].rd));
      e = q.pop_front();
      if (e.sf) m_flags = e.flags;
    end
    if (fsh) q.delete();
    if (do_push) begin
      e.result = res; e.flags = fl; e.sf = sf; e.rd = rd;
      q.push_back(e);
    end
    if (q.size() != 0) begin
      disp_result = q[0].result;
      disp_rd     = q[0].rd;
    end
    @(posedge clk);
    #1;
    check({tag, "_count"},  32'(count),         32'(q.size()));
    check({tag, "_flags"},  32'(flags_n_z_v_c), 32'(m_flags));
    check({tag, "_head"},   32'(out_result),    32'(disp_result));
    check({tag, "_headrd"}, 32'(out_rd),        32'(disp_rd));
  endtask

  task automatic idle(input logic ordy, input string tag);
    cycle(1'b0, 8'h00, 4'h0, 1'b0, 3'd0, ordy, 1'b0, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_result = '0; in_flags_n_z_v_c = '0; in_set_flags = 1'b0;
    in_rd = '0; flush = 1'b0; out_ready = 1'b0;
    m_flags = 4'b0000; disp_result = 8'h00; disp_rd = 3'd0;

    #2;
    check_reset_values("por");
    #10;
    rst_n = 1'b1;

    // Single op, pushed on the first edge after reset release.
    cycle(1'b1, 8'hE1, 4'b1000, 1'b1, 3'd3, 1'b1, 1'b0, "single_push");
    idle(1'b1, "single_pop");

    // Backpressure: third push rejected, then in-order drain.
    cycle(1'b1, 8'h11, 4'b0000, 1'b0, 3'd1, 1'b0, 1'b0, "bp_push1");
    cycle(1'b1, 8'h22, 4'b0000, 1'b0, 3'd2, 1'b0, 1'b0, "bp_push2");
    cycle(1'b1, 8'h33, 4'b0000, 1'b0, 3'd3, 1'b0, 1'b0, "bp_blocked");
    idle(1'b1, "bp_pop1");
    idle(1'b1, "bp_pop2");

    // Full with push and pop together: only the pop happens.
    cycle(1'b1, 8'hA1, 4'b0000, 1'b0, 3'd4, 1'b0, 1'b0, "full_fill1");
    cycle(1'b1, 8'hA2, 4'b0000, 1'b0, 3'd5, 1'b0, 1'b0, "full_fill2");
    cycle(1'b1, 8'hA3, 4'b0000, 1'b0, 3'd6, 1'b1, 1'b0, "full_pushpop");
    idle(1'b1, "full_drain");

    // Set-flags mask.
    cycle(1'b1, 8'h01, 4'b0100, 1'b1, 3'd1, 1'b0, 1'b0, "mask_push1");
    cycle(1'b1, 8'h02, 4'b0001, 1'b0, 3'd2, 1'b0, 1'b0, "mask_push2");
    idle(1'b1, "mask_pop1");
    idle(1'b1, "mask_pop2");

    // Streaming: one push and one retire per cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'h40 + 8'(i), 4'(i), 1'(i), 3'(i), 1'b1, 1'b0, "stream");
    end
    idle(1'b1, "stream_drain");

    // Flush beats push and pop; flags stay put.
    cycle(1'b1, 8'hC1, 4'b1111, 1'b1, 3'd1, 1'b0, 1'b0, "flush_fill1");
    cycle(1'b1, 8'hC2, 4'b0110, 1'b1, 3'd2, 1'b0, 1'b0, "flush_fill2");
    cycle(1'b1, 8'hC3, 4'b0011, 1'b1, 3'd3, 1'b1, 1'b1, "flush");
    idle(1'b1, "flush_after");

    // Async reset with a full FIFO and non-zero flags.
    cycle(1'b1, 8'hD0, 4'b1010, 1'b1, 3'd7, 1'b0, 1'b0, "ar_flag_push");
    idle(1'b1, "ar_flag_pop");
    cycle(1'b1, 8'hD1, 4'b0101, 1'b1, 3'd1, 1'b0, 1'b0, "ar_fill1");
    cycle(1'b1, 8'hD2, 4'b0011, 1'b1, 3'd2, 1'b0, 1'b0, "ar_fill2");
    in_valid = 1'b0; out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    q.delete();
    m_flags = 4'b0000; disp_result = 8'h00; disp_rd = 3'd0;
    #2;
    rst_n = 1'b1;
    cycle(1'b1, 8'hF5, 4'b0010, 1'b1, 3'd5, 1'b0, 1'b0, "post_rst_push");
    idle(1'b1, "post_rst_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: N, default 8, datapath width of the ALU result.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream ALU/rotater result is valid.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 in_result  input  N  ALU result, e.g. rotater out.
REQ-007 in_flags_n_z_v_c  input  4  flags from the ALU op: bit3 N, bit2 Z, bit1 V, bit0 C.
REQ-008 in_set_flags  input  1  this op updates the architectural flags when retired.
REQ-009 in_rd  input  3  destination register address.
REQ-010 flush  input  1  synchronous discard of all buffered entries.
REQ-011 out_valid  output  1  head entry is valid for writeback.
REQ-012 out_ready  input  1  writeback consumes the head entry this cycle.
REQ-013 out_result  output  N  head entry result.
REQ-014 out_rd  output  3  head entry destination address.
REQ-015 flags_n_z_v_c  output  4  architectural flags register.
REQ-016 count  output  2  number of buffered entries, 0..2.

Function
REQ-017 Storage: 2-entry FIFO; each entry holds result, flags, set_flags, rd.
REQ-018 Push occurs on the rising edge where in_valid=1 and in_ready=1.
REQ-019 Pop occurs on the rising edge where out_valid=1 and out_ready=1.
REQ-020 in_ready = (count != 2); it depends on registered state only, with no combinational path from out_ready.
REQ-021 out_valid = (count != 0); out_result and out_rd reflect the oldest entry and are driven from registers only.
REQ-022 Latency: an entry pushed at edge k is presented at out_valid from edge k, so it is visible in cycle k+1; there is no bypass from input to output.
REQ-023 Ordering: strict FIFO; entries retire in push order.
REQ-024 Simultaneous push and pop with count=1: count stays 1, and the new entry becomes the head after the old one leaves.
REQ-025 Simultaneous push and pop with count=0: cannot occur because out_valid=0; only the push takes effect.
REQ-026 count=2: push is blocked by in_ready=0; a pop in the same cycle takes effect and in_ready returns to 1 in the next cycle.
REQ-027 Flags update: on a pop whose entry has set_flags=1, flags_n_z_v_c takes that entry's stored flags at the same edge.
REQ-028 On a pop with set_flags=0, flags_n_z_v_c holds its value.
REQ-029 Flags never change on a push, and never change without a pop.
REQ-030 Flush: at the edge where flush=1, count becomes 0 and all entries are discarded.
REQ-031 Flush has priority over a push and over a pop in the same cycle; no flags update occurs and flags_n_z_v_c is unchanged.
REQ-032 Read and write pointers are 1 bit each and wrap modulo 2; count is tracked explicitly.
REQ-033 When out_valid=0, out_result and out_rd hold the last driven values and carry no meaning.

Reset
REQ-034 While rst_n=0, asynchronously and regardless of clk: count=0, in_ready=1, out_valid=0, pointers=0, flags_n_z_v_c=4'b0000, out_result=0, out_rd=0.
REQ-035 Reset asserted mid-operation discards all buffered entries, and no flags update occurs.
REQ-036 The first push can occur on the first rising edge after rst_n deasserts.

Verification
REQ-037 Single op: push result=8'hE1, flags=4'b1000, set_flags=1, rd=3, with out_ready=1 -> next cycle out_valid=1, out_result=8'hE1, out_rd=3; after the pop edge, flags_n_z_v_c=4'b1000 and count=0.
REQ-038 Backpressure: out_ready=0, push 8'h11, 8'h22, 8'h33 on consecutive cycles -> count=2, in_ready=0, 8'h33 not accepted; raise out_ready -> 8'h11 then 8'h22 retire in order.
REQ-039 Set-flags mask: pop entries flags=4'b0100/set=1, then flags=4'b0001/set=0 -> flags_n_z_v_c=4'b0100 after both pops.
REQ-040 Streaming: in_valid=1 and out_ready=1 every cycle for 10 ops -> count stays 1 and one result retires per cycle, in order.
REQ-041 Flush: count=2 with flush=1, in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, flags unchanged.
REQ-042 Async reset: with count=2, flags=4'b1010, drop rst_n between clock edges -> outputs go to reset values immediately, before the next edge.
